// File: rtl/calendar_pkg.sv
// Shared types and BCD helpers for the calendar datapath.
package calendar_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        SUN = 3'd0,
        MON = 3'd1,
        TUE = 3'd2,
        WED = 3'd3,
        THU = 3'd4,
        FRI = 3'd5,
        SAT = 3'd6
    } weekday_t;

    localparam logic [7:0] FEB = 8'h02;
    localparam logic [7:0] APR = 8'h04;
    localparam logic [7:0] JUN = 8'h06;
    localparam logic [7:0] SEP = 8'h09;
    localparam logic [7:0] NOV = 8'h11;
    localparam logic [7:0] DEC = 8'h12;

    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
        case (month)
            FEB:                days_in_month = leap ? 8'h29 : 8'h28;
            APR, JUN, SEP, NOV: days_in_month = 8'h30;
            default:            days_in_month = 8'h31;
        endcase
    endfunction

    // Returns {carry, digit}; 9 rolls to 0 with carry set.
    function automatic logic [4:0] bcd_inc(input bcd_digit_t digit);
        if (digit == 4'd9)
            bcd_inc = {1'b1, 4'd0};
        else
            bcd_inc = {1'b0, digit + 4'd1};
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] value);
        logic [4:0] lo;
        lo = bcd_inc(value[3:0]);
        bcd2_inc = lo[4] ? {value[7:4] + 4'd1, 4'd0} : {value[7:4], lo[3:0]};
    endfunction

endpackage

// File: rtl/leap_year_bcd.sv
// Combinational Gregorian leap-year detector working directly on BCD digits.
module leap_year_bcd
    import calendar_pkg::*;
#(
    parameter int YEAR_DIGITS = 4
) (
    input  logic [4*YEAR_DIGITS-1:0] year,
    output logic                     leap
);

    // Two-digit number tens*10+ones is divisible by 4.
    function automatic logic m4(input bcd_digit_t t, input bcd_digit_t o);
        if (!t[0])
            m4 = (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
        else
            m4 = (o == 4'd2) || (o == 4'd6);
    endfunction

    bcd_digit_t ones, tens, hundreds, thousands;
    logic       div4, div100, div400;

    assign ones      = year[3:0];
    assign tens      = year[7:4];
    assign hundreds  = year[11:8];
    assign thousands = year[15:12];

    // Digits above thousands never matter since 10000 is a multiple of 400.
    generate
        if (YEAR_DIGITS > 4) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^year[4*YEAR_DIGITS-1:16];
        end
    endgenerate

    assign div4   = m4(tens, ones);
    assign div100 = (tens == 4'd0) && (ones == 4'd0);
    assign div400 = div100 && m4(thousands, hundreds);
    assign leap   = div4 && (!div100 || div400);

endmodule

// File: rtl/bcd_calendar_counter.sv
// Registered BCD year/month/day/weekday counter with validated parallel load.
module bcd_calendar_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_DIGITS   = 4,
    parameter int RESET_YEAR    = 2000,
    parameter int RESET_WEEKDAY = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load,
    input  logic [4*YEAR_DIGITS-1:0] ld_year,
    input  logic [7:0]               ld_month,
    input  logic [7:0]               ld_day,
    input  logic [2:0]               ld_weekday,
    output logic [4*YEAR_DIGITS-1:0] year,
    output logic [7:0]               month,
    output logic [7:0]               day,
    output logic [2:0]               weekday,
    output logic                     leap,
    output logic                     eoy,
    output logic                     wrap,
    output logic                     ld_err
);

    localparam int YW = 4 * YEAR_DIGITS;

    function automatic logic [YW-1:0] dec_to_bcd(input int unsigned value);
        logic [YW-1:0] r;
        int unsigned   v;
        r = '0;
        v = value;
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [YW-1:0] RESET_YEAR_BCD = dec_to_bcd(RESET_YEAR);
    localparam weekday_t      RESET_WD       = weekday_t'(3'(RESET_WEEKDAY));

    logic [YW-1:0] year_q, year_d, year_inc;
    logic [7:0]    month_q, month_d, day_q, day_d;
    weekday_t      weekday_q, weekday_d;
    logic          eoy_q, eoy_d, wrap_q, wrap_d, ld_err_q, ld_err_d;
    logic          year_carry, cur_leap, ld_leap, ld_nibbles_ok, ld_ok;

    leap_year_bcd #(.YEAR_DIGITS(YEAR_DIGITS)) u_cur_leap (.year(year_q),  .leap(cur_leap));
    leap_year_bcd #(.YEAR_DIGITS(YEAR_DIGITS)) u_ld_leap  (.year(ld_year), .leap(ld_leap));

    // Ripple-carry BCD increment of the whole year; final carry means all-9s wrapped.
    always_comb begin
        year_inc   = year_q;
        year_carry = 1'b1;
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (year_carry)
                {year_carry, year_inc[4*i +: 4]} = bcd_inc(year_q[4*i +: 4]);
        end
    end

    always_comb begin
        ld_nibbles_ok = (ld_month[3:0] <= 4'd9) && (ld_month[7:4] <= 4'd9) &&
                        (ld_day[3:0] <= 4'd9)   && (ld_day[7:4] <= 4'd9);
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (ld_year[4*i +: 4] > 4'd9)
                ld_nibbles_ok = 1'b0;
        end
    end

    assign ld_ok = ld_nibbles_ok &&
                   (ld_month >= 8'h01) && (ld_month <= DEC) &&
                   (ld_day >= 8'h01) && (ld_day <= days_in_month(ld_month, ld_leap)) &&
                   (ld_weekday <= 3'd6);

    always_comb begin
        year_d    = year_q;
        month_d   = month_q;
        day_d     = day_q;
        weekday_d = weekday_q;
        eoy_d     = 1'b0;
        wrap_d    = 1'b0;
        ld_err_d  = 1'b0;
        if (load) begin
            if (ld_ok) begin
                year_d    = ld_year;
                month_d   = ld_month;
                day_d     = ld_day;
                weekday_d = weekday_t'(ld_weekday);
            end else begin
                ld_err_d = 1'b1;
            end
        end else if (en) begin
            weekday_d = (weekday_q == SAT) ? SUN : weekday_t'(weekday_q + 3'd1);
            if (day_q != days_in_month(month_q, cur_leap)) begin
                day_d = bcd2_inc(day_q);
            end else begin
                day_d = 8'h01;
                if (month_q != DEC) begin
                    month_d = bcd2_inc(month_q);
                end else begin
                    month_d = 8'h01;
                    year_d  = year_inc;
                    eoy_d   = 1'b1;
                    wrap_d  = year_carry;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            year_q    <= RESET_YEAR_BCD;
            month_q   <= 8'h01;
            day_q     <= 8'h01;
            weekday_q <= RESET_WD;
            eoy_q     <= 1'b0;
            wrap_q    <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            year_q    <= year_d;
            month_q   <= month_d;
            day_q     <= day_d;
            weekday_q <= weekday_d;
            eoy_q     <= eoy_d;
            wrap_q    <= wrap_d;
            ld_err_q  <= ld_err_d;
        end
    end

    assign year    = year_q;
    assign month   = month_q;
    assign day     = day_q;
    assign weekday = weekday_q;
    assign leap    = cur_leap;
    assign eoy     = eoy_q;
    assign wrap    = wrap_q;
    assign ld_err  = ld_err_q;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Bench for bcd_calendar_counter: integer calendar model, 4- and 6-digit instances.
module tb_bcd_calendar_counter;

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [15:0] ld_year;
    logic [23:0] ld_year6;
    logic [7:0]  ld_month, ld_day;
    logic [2:0]  ld_weekday;

    logic [15:0] year4;
    logic [23:0] year6;
    logic [7:0]  month4, day4, month6, day6;
    logic [2:0]  wd4, wd6;
    logic        leap4, eoy4, wrap4, err4, leap6, eoy6, wrap6, err6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ld_year6 = {8'h00, ld_year};

    bcd_calendar_counter #(.YEAR_DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day), .ld_weekday(ld_weekday),
        .year(year4), .month(month4), .day(day4), .weekday(wd4),
        .leap(leap4), .eoy(eoy4), .wrap(wrap4), .ld_err(err4)
    );

    bcd_calendar_counter #(.YEAR_DIGITS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .ld_year(ld_year6), .ld_month(ld_month), .ld_day(ld_day), .ld_weekday(ld_weekday),
        .year(year6), .month(month6), .day(day6), .weekday(wd6),
        .leap(leap6), .eoy(eoy6), .wrap(wrap6), .ld_err(err6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain integer calendar) ----------------
    function automatic bit is_leap(input int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int dim(input int m, input int y);
        if (m == 2) return is_leap(y) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [31:0] to_bcd(input int value, input int n);
        logic [31:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    bit m_valid = 0;
    int my, my6, mm, md, mwd;
    bit m_eoy, m_wrap, m_wrap6, m_err;

    always @(posedge clk) begin
        bit nib_ok, ok;
        int ly, lm, ldy;
        m_eoy = 0; m_wrap = 0; m_wrap6 = 0; m_err = 0;
        if (!rst_n) begin
            m_valid = 1;
            my = 2000; my6 = 2000; mm = 1; md = 1; mwd = 6;
        end else if (load) begin
            nib_ok = 1;
            ly = 0;
            for (int i = 3; i >= 0; i--) begin
                if (ld_year[4*i +: 4] > 9) nib_ok = 0;
                ly = ly * 10 + int'(ld_year[4*i +: 4]);
            end
            if (ld_month[7:4] > 9 || ld_month[3:0] > 9 || ld_day[7:4] > 9 || ld_day[3:0] > 9)
                nib_ok = 0;
            lm  = 10 * int'(ld_month[7:4]) + int'(ld_month[3:0]);
            ldy = 10 * int'(ld_day[7:4]) + int'(ld_day[3:0]);
            ok = nib_ok && lm >= 1 && lm <= 12 && ldy >= 1 && ldy <= dim(lm, ly) && ld_weekday <= 6;
            if (ok) begin
                my = ly; my6 = ly; mm = lm; md = ldy; mwd = int'(ld_weekday);
            end else begin
                m_err = 1;
            end
        end else if (en) begin
            mwd = (mwd + 1) % 7;
            if (md < dim(mm, my)) begin
                md++;
            end else begin
                md = 1;
                if (mm < 12) begin
                    mm++;
                end else begin
                    mm = 1;
                    m_eoy = 1;
                    my++;
                    if (my == 10000) begin my = 0; m_wrap = 1; end
                    my6++;
                    if (my6 == 1000000) begin my6 = 0; m_wrap6 = 1; end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("year4",   32'(year4),  to_bcd(my, 4));
            chk("month4",  32'(month4), to_bcd(mm, 2));
            chk("day4",    32'(day4),   to_bcd(md, 2));
            chk("wd4",     32'(wd4),    32'(mwd));
            chk("leap4",   32'(leap4),  32'(is_leap(my)));
            chk("eoy4",    32'(eoy4),   32'(m_eoy));
            chk("wrap4",   32'(wrap4),  32'(m_wrap));
            chk("ld_err4", 32'(err4),   32'(m_err));
            chk("year6",   32'(year6),  to_bcd(my6, 6));
            chk("month6",  32'(month6), to_bcd(mm, 2));
            chk("day6",    32'(day6),   to_bcd(md, 2));
            chk("wd6",     32'(wd6),    32'(mwd));
            chk("leap6",   32'(leap6),  32'(is_leap(my6)));
            chk("eoy6",    32'(eoy6),   32'(m_eoy));
            chk("wrap6",   32'(wrap6),  32'(m_wrap6));
            chk("ld_err6", 32'(err6),   32'(m_err));
        end
    end

    // Year length seen on the DUT between consecutive eoy pulses during sweeps.
    bit sweep_armed = 0;
    int days_seen = 0;
    logic [2:0] prev_wd = 3'd0;
    always @(negedge clk) begin
        if (!sweep_armed) begin
            days_seen = 0;
        end else begin
            if (wd4 != prev_wd) days_seen++;
            if (eoy4) begin
                chk("year_len", 32'(days_seen), is_leap(my - 1) ? 32'd366 : 32'd365);
                days_seen = 0;
            end
        end
        prev_wd = wd4;
    end

    // ---------------- drivers ----------------
    task automatic set_ld(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d,
                          input logic [2:0] w);
        ld_year = y; ld_month = m; ld_day = d; ld_weekday = w;
    endtask

    // Called at a negedge; applies inputs for one posedge, returns at the next negedge.
    task automatic apply(input logic e, input logic l);
        en = e; load = l;
        @(negedge clk);
        en = 0; load = 0;
    endtask

    task automatic do_load(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d,
                           input logic [2:0] w);
        set_ld(y, m, d, w);
        apply(0, 1);
    endtask

    task automatic sweep(input logic [15:0] start_y, input int end_y);
        int n;
        do_load(start_y, 8'h01, 8'h01, 3'd3);
        #1;
        sweep_armed = 1;
        en = 1;
        n = 0;
        while (!(my == end_y && mm == 12 && md == 31) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        en = 0;
        chk("sweep_bound", 32'(n < 5000), 32'd1);
        #1;
        sweep_armed = 0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; en = 0; load = 0;
        set_ld(16'h0000, 8'h00, 8'h00, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Reset values
        chk("rst_year", 32'(year4), 32'h2000);
        chk("rst_md",   32'({month4, day4}), 32'h0101);
        chk("rst_wd",   32'(wd4), 32'd6);
        chk("rst_leap", 32'(leap4), 32'd1);
        chk("rst_pulses", 32'({eoy4, wrap4, err4}), 32'd0);

        // Century non-leap year
        do_load(16'h1900, 8'h02, 8'h28, 3'd3);
        apply(1, 0);
        chk("1900_date", 32'({year4, month4, day4}), 32'h19000301);
        chk("1900_wd",   32'(wd4), 32'd4);
        chk("1900_leap", 32'(leap4), 32'd0);

        // 400-year leap
        do_load(16'h2000, 8'h02, 8'h28, 3'd1);
        apply(1, 0);
        chk("2000_feb29", 32'({year4, month4, day4}), 32'h20000229);
        chk("2000_leap_a", 32'(leap4), 32'd1);
        apply(1, 0);
        chk("2000_mar01", 32'({year4, month4, day4}), 32'h20000301);
        chk("2000_leap_b", 32'(leap4), 32'd1);

        // Year end
        do_load(16'h2024, 8'h12, 8'h31, 3'd2);
        chk("2024_leap", 32'(leap4), 32'd1);
        apply(1, 0);
        chk("2025_date", 32'({year4, month4, day4}), 32'h20250101);
        chk("2025_wd",   32'(wd4), 32'd3);
        chk("2025_eoy",  32'({eoy4, wrap4}), 32'b10);
        chk("2025_leap", 32'(leap4), 32'd0);
        apply(0, 0);
        chk("eoy_drop",  32'(eoy4), 32'd0);

        // All-9s wrap
        do_load(16'h9999, 8'h12, 8'h31, 3'd5);
        apply(1, 0);
        chk("wrap_date",  32'({year4, month4, day4}), 32'h00000101);
        chk("wrap_pulse", 32'({eoy4, wrap4}), 32'b11);
        chk("wrap_leap",  32'(leap4), 32'd1);
        chk("wide_year",  32'(year6), 32'h010000);
        chk("wide_wrap",  32'({eoy6, wrap6}), 32'b10);

        // Rejected loads
        do_load(16'h2023, 8'h02, 8'h29, 3'd1);
        chk("bad_feb29_err",  32'(err4), 32'd1);
        chk("bad_feb29_keep", 32'({year4, month4, day4}), 32'h00000101);
        do_load(16'h2023, 8'h13, 8'h01, 3'd1);
        chk("bad_month", 32'(err4), 32'd1);
        do_load(16'h20A3, 8'h01, 8'h01, 3'd1);
        chk("bad_nibble", 32'(err4), 32'd1);
        do_load(16'h2023, 8'h04, 8'h31, 3'd1);
        chk("bad_apr31", 32'(err4), 32'd1);
        do_load(16'h2023, 8'h01, 8'h00, 3'd1);
        chk("bad_day0", 32'(err4), 32'd1);
        do_load(16'h2023, 8'h01, 8'h01, 3'd7);
        chk("bad_wd7", 32'(err4), 32'd1);
        do_load(16'h2024, 8'h02, 8'h29, 3'd4);
        chk("ok_feb29", 32'({err4, year4, month4, day4}), 33'h020240229);

        // Load beats enable
        set_ld(16'h2023, 8'h06, 8'h10, 3'd6);
        apply(1, 1);
        chk("load_wins", 32'({year4, month4, day4}), 32'h20230610);
        chk("load_wins_wd", 32'(wd4), 32'd6);

        // Reset beats load
        set_ld(16'h1999, 8'h07, 8'h04, 3'd0);
        rst_n = 0;
        apply(1, 1);
        rst_n = 1;
        chk("rst_over_load", 32'({year4, month4, day4}), 32'h20000101);
        chk("rst_over_load_wd", 32'(wd4), 32'd6);

        // Leap-rule sweeps around century boundaries
        sweep(16'h1896, 1904);
        sweep(16'h1996, 2004);
        sweep(16'h2096, 2104);
        sweep(16'h2396, 2404);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
